// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Debug run/step/halt sequencer producing the clock enable and
//               synchronous reset for the single-cycle CPU core.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32,
    parameter int RST_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst_req,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [7:0]       step_cnt,
    input  logic             bp_set,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  pc_in,
    output logic             cpu_ce,
    output logic             cpu_reset,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_HALT  = 2'b01,
        ST_RUN   = 2'b10,
        ST_STEP  = 2'b11
    } state_t;

    localparam int                c_RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(RST_CYC - 1);

    state_t             state_q, state_d;
    logic [c_RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic [PC_W-1:0]    bp_reg_q, bp_reg_d;
    logic [7:0]         remain_q, remain_d;
    logic               skip_q, skip_d;

    logic               w_pc_eq;
    logic               w_bp_match;
    logic               w_active;
    logic               w_ce;

    // skip lets the instruction we halted on execute once after resuming
    assign w_pc_eq    = (pc_in == bp_reg_q);
    assign w_bp_match = bp_en & w_pc_eq & ~skip_q;
    assign w_active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign w_ce       = w_active & ~halt_req & ~w_bp_match & ~soft_rst_req;

    assign cpu_ce     = w_ce;
    assign cpu_reset  = cpu_reset_q;
    assign halted     = (state_q == ST_HALT);
    assign bp_hit     = bp_hit_q;
    assign state      = state_q;
    assign instr_cnt  = instr_cnt_q;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        bp_hit_d    = bp_hit_q;
        instr_cnt_d = instr_cnt_q;
        bp_reg_d    = bp_reg_q;
        remain_d    = remain_q;
        skip_d      = skip_q;

        if (bp_set) begin
            bp_reg_d = bp_addr;
        end

        if (w_ce) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
            skip_d      = 1'b0;
        end

        case (state_q)
            ST_RESET: begin
                instr_cnt_d = '0;
                bp_hit_d    = 1'b0;
                if (rst_cnt_q == c_RC_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (!halt_req && (step_req || run_req)) begin
                    bp_hit_d = 1'b0;
                    skip_d   = bp_en & w_pc_eq;
                    if (step_req) begin
                        state_d  = ST_STEP;
                        remain_d = (step_cnt == 8'd0) ? 8'd1 : step_cnt;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (w_bp_match) begin
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                end else if (state_q == ST_STEP) begin
                    // w_ce is necessarily high on this branch
                    if (remain_q <= 8'd1) begin
                        state_d  = ST_HALT;
                        remain_d = 8'd0;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
            end
        endcase

        if (soft_rst_req) begin
            state_d     = ST_RESET;
            rst_cnt_d   = '0;
            instr_cnt_d = '0;
            bp_hit_d    = 1'b0;
            remain_d    = 8'd0;
            skip_d      = 1'b0;
        end

        cpu_reset_d = (state_d == ST_RESET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
            bp_hit_q    <= 1'b0;
            instr_cnt_q <= '0;
            bp_reg_q    <= '0;
            remain_q    <= 8'd0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cpu_reset_q <= cpu_reset_d;
            bp_hit_q    <= bp_hit_d;
            instr_cnt_q <= instr_cnt_d;
            bp_reg_q    <= bp_reg_d;
            remain_q    <= remain_d;
            skip_q      <= skip_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Directed self-checking bench for cpu_run_ctrl (32- and 4-bit
//               counter builds driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst_req = 1'b0;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  step_cnt = 8'd0;
    logic        bp_set = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic        bp_en = 1'b0;
    logic [31:0] pc_in = 32'd0;

    logic        cpu_ce, cpu_reset, halted, bp_hit;
    logic [1:0]  state;
    logic [31:0] instr_cnt;

    logic        ce4, reset4, halted4, bp_hit4;
    logic [1:0]  state4;
    logic [3:0]  instr_cnt4;

    int n_checks = 0;
    int n_errors = 0;
    int nce;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYC(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .run_req(run_req),
        .halt_req(halt_req), .step_req(step_req), .step_cnt(step_cnt), .bp_set(bp_set),
        .bp_addr(bp_addr), .bp_en(bp_en), .pc_in(pc_in), .cpu_ce(cpu_ce),
        .cpu_reset(cpu_reset), .halted(halted), .bp_hit(bp_hit), .state(state),
        .instr_cnt(instr_cnt)
    );

    cpu_run_ctrl #(.PC_W(32), .CNT_W(4), .RST_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .run_req(run_req),
        .halt_req(halt_req), .step_req(step_req), .step_cnt(step_cnt), .bp_set(bp_set),
        .bp_addr(bp_addr), .bp_en(bp_en), .pc_in(pc_in), .cpu_ce(ce4),
        .cpu_reset(reset4), .halted(halted4), .bp_hit(bp_hit4), .state(state4),
        .instr_cnt(instr_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issue a step request and count enabled cycles within a bounded window
    task automatic do_step(input logic [7:0] n, output int cnt);
        step_cnt = n;
        step_req = 1'b1;
        #1;
        step_clk();
        step_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cpu_ce) cnt++;
            step_clk();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-on reset and release
        repeat (3) step_clk();
        chk("rst_state", state, 2'b00);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_ce", cpu_ce, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_bp_hit", bp_hit, 1'b0);
        chk("rst_cnt", instr_cnt, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step_clk();
            chk("rst_hold_reset", cpu_reset, 1'b1);
            chk("rst_hold_state", state, 2'b00);
        end
        step_clk();
        chk("halt_state", state, 2'b01);
        chk("halt_halted", halted, 1'b1);
        chk("halt_cpu_reset", cpu_reset, 1'b0);
        chk("halt_ce", cpu_ce, 1'b0);
        chk("halt_cnt", instr_cnt, 0);

        // stepping: 3 instructions, then step_cnt=0 treated as 1
        do_step(8'd3, nce);
        chk("step3_ce_cycles", nce, 3);
        chk("step3_cnt", instr_cnt, 3);
        chk("step3_state", state, 2'b01);
        do_step(8'd0, nce);
        chk("step0_ce_cycles", nce, 1);
        chk("step0_cnt", instr_cnt, 4);

        // breakpoint at 0x10 during free run
        bp_addr = 32'h10; bp_set = 1'b1; bp_en = 1'b1;
        step_clk();
        bp_set = 1'b0;
        pc_in = 32'h0; run_req = 1'b1;
        #1;
        step_clk();
        run_req = 1'b0;
        chk("run_state", state, 2'b10);
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(i * 4);
            #1;
            chk("run_ce", cpu_ce, 1'b1);
            step_clk();
        end
        pc_in = 32'h10;
        #1;
        chk("bp_ce_blocked", cpu_ce, 1'b0);
        step_clk();
        chk("bp_state", state, 2'b01);
        chk("bp_hit_set", bp_hit, 1'b1);
        chk("bp_cnt", instr_cnt, 8);

        // resume: halted breakpoint instruction executes once
        run_req = 1'b1;
        #1;
        step_clk();
        run_req = 1'b0;
        #1;
        chk("resume_state", state, 2'b10);
        chk("resume_bp_hit_clr", bp_hit, 1'b0);
        chk("resume_skip_ce", cpu_ce, 1'b1);
        step_clk();
        chk("resume_cnt", instr_cnt, 9);
        pc_in = 32'h14;
        #1;
        chk("resume_ce_next", cpu_ce, 1'b1);
        step_clk();

        // halt_req outranks a simultaneous breakpoint match
        pc_in = 32'h10; halt_req = 1'b1;
        #1;
        chk("halt_bp_ce", cpu_ce, 1'b0);
        step_clk();
        halt_req = 1'b0;
        chk("halt_bp_state", state, 2'b01);
        chk("halt_bp_hit", bp_hit, 1'b0);
        chk("halt_bp_cnt", instr_cnt, 10);

        // run_req and step_req together: STEP wins
        pc_in = 32'h20; step_cnt = 8'd2; run_req = 1'b1; step_req = 1'b1;
        #1;
        step_clk();
        run_req = 1'b0; step_req = 1'b0;
        chk("both_req_state", state, 2'b11);
        nce = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cpu_ce) nce++;
            step_clk();
        end
        chk("both_req_ce_cycles", nce, 2);
        chk("both_req_cnt", instr_cnt, 12);

        // soft reset in the middle of a long step
        pc_in = 32'h30; step_cnt = 8'd10; step_req = 1'b1;
        #1;
        step_clk();
        step_req = 1'b0;
        #1;
        chk("soft_pre_ce0", cpu_ce, 1'b1);
        step_clk();
        chk("soft_pre_ce1", cpu_ce, 1'b1);
        step_clk();
        chk("soft_pre_cnt", instr_cnt, 14);
        soft_rst_req = 1'b1;
        #1;
        chk("soft_ce", cpu_ce, 1'b0);
        step_clk();
        soft_rst_req = 1'b0;
        chk("soft_state", state, 2'b00);
        chk("soft_cpu_reset", cpu_reset, 1'b1);
        chk("soft_cnt", instr_cnt, 0);
        for (int i = 1; i <= 3; i++) begin
            step_clk();
            chk("soft_hold_reset", cpu_reset, 1'b1);
        end
        step_clk();
        chk("soft_done_state", state, 2'b01);
        chk("soft_done_reset", cpu_reset, 1'b0);

        // async reset assertion mid-RUN
        run_req = 1'b1;
        #1;
        step_clk();
        run_req = 1'b0;
        #1;
        chk("async_pre_ce", cpu_ce, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_ce", cpu_ce, 1'b0);
        chk("async_state", state, 2'b00);
        chk("async_cpu_reset", cpu_reset, 1'b1);
        step_clk();
        rst_n = 1'b1;
        repeat (4) step_clk();
        chk("async_done_state", state, 2'b01);
        chk("async_done_cnt4", instr_cnt4, 4'd0);

        // 4-bit counter wrap
        do_step(8'd15, nce);
        chk("wrap_ce_cycles", nce, 15);
        chk("wrap_pre_cnt4", instr_cnt4, 4'hF);
        do_step(8'd1, nce);
        chk("wrap_cnt4", instr_cnt4, 4'h0);
        chk("wrap_cnt32", instr_cnt, 16);

        // breakpoint loaded while running at the next PC
        pc_in = 32'h40; run_req = 1'b1;
        #1;
        step_clk();
        run_req = 1'b0;
        pc_in = 32'h44; bp_addr = 32'h48; bp_set = 1'b1;
        #1;
        chk("bpset_ce", cpu_ce, 1'b1);
        step_clk();
        bp_set = 1'b0;
        pc_in = 32'h48;
        #1;
        chk("bpset_match_ce", cpu_ce, 1'b0);
        step_clk();
        chk("bpset_state", state, 2'b01);
        chk("bpset_hit", bp_hit, 1'b1);
        chk("bpset_cnt", instr_cnt, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
